dmem_bytelane: RTL and testbench

//  Parametrised data memory for the RV32 core with RISC-V sub-word access: LB/LH/LW/LBU/LHU, SB/SH/SW.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 62 ++++++
 rtl/dmem_bytelane.sv | 169 ++++++++++++++++
 tb/tb_dmem_bytelane.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
//   mem_size_e  : access size encoding carried on req_size (byte, half, word, illegal)
//   mem_state_e : top-level FSM states (zero-fill sweep, normal operation)
//   misaligned(): true when the access size is illegal or not naturally aligned to off
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    // Illegal size is folded in here so callers only OR in the range check.
    function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between the 32-bit RAM word and right-aligned core data.
// Ports:
//   st_size, st_off, st_wdata : store request (size, byte offset, right-aligned data)
//   st_be, st_wdata_lane      : byte-lane write strobes and data replicated onto the lanes
//   ld_size, ld_off, ld_uns   : registered load attributes (uns=1 zero-extends)
//   ld_raw                    : raw word read from the RAM
//   ld_rdata                  : selected and extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_e   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_lane,
    input  mem_size_e   ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_uns,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_rdata
);

    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data means the strobe alone decides which lanes land.
    always_comb begin
        st_be         = 4'b0000;
        st_wdata_lane = st_wdata;
        unique case (st_size)
            SZ_B: begin
                st_be         = 4'b0001 << st_off;
                st_wdata_lane = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_be         = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_lane = {2{st_wdata[15:0]}};
            end
            SZ_W: begin
                st_be         = 4'b1111;
                st_wdata_lane = st_wdata;
            end
            default: begin
                st_be         = 4'b0000;
                st_wdata_lane = st_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
        unique case (ld_size)
            SZ_B:    ld_rdata = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_rdata = {{16{~ld_uns & ld_half[15]}}, ld_half};
            default: ld_rdata = ld_raw;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// RV32 data memory with sub-word access, valid/ready request port and a 1-cycle response.
// After reset the whole array is zero-filled, one word per cycle, while init_busy is high.
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   req_valid/ready : request handshake (ready = !init_busy)
//   req_we          : 1=store, 0=load
//   req_addr        : byte address
//   req_size        : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    : loads only, 1=zero-extend
//   req_wdata       : right-aligned store data
//   rsp_valid       : one pulse per accepted request, the cycle after accept
//   rsp_rdata       : extended load data, 0 for stores and errors
//   rsp_err         : misaligned, out-of-range or illegal size
//   init_busy       : zero-fill sweep in progress
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH_WORDS - 1);

    mem_state_e state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    mem_size_e        req_sz;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    logic             range_err;
    logic             req_err;
    logic             accept;

    logic [3:0]       st_be;
    logic [31:0]      st_wdata_lane;

    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wd;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             ld_q;
    logic [31:0]      raw_q;
    mem_size_e        size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic [31:0]      ld_rdata;

    assign init_busy = (state_q == ST_INIT);
    assign req_ready = ~init_busy;

    assign req_sz    = mem_size_e'(req_size);
    assign req_idx   = req_addr[IDX_W+1:2];
    assign req_off   = req_addr[1:0];
    // Any address bit above the array span set means out of range.
    assign range_err = ((req_addr >> (IDX_W + 2)) != '0);
    assign req_err   = misaligned(req_sz, req_off) | range_err;
    assign accept    = req_valid & req_ready & ~reset;

    dmem_lane_align u_align (
        .st_size       (req_sz),
        .st_off        (req_off),
        .st_wdata      (req_wdata),
        .st_be         (st_be),
        .st_wdata_lane (st_wdata_lane),
        .ld_size       (size_q),
        .ld_off        (off_q),
        .ld_uns        (uns_q),
        .ld_raw        (raw_q),
        .ld_rdata      (ld_rdata)
    );

    // FSM: sweep every word once, then run until the next reset.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LastIdx) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Single write port shared by the sweep and stores; the two never overlap.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = req_idx;
        mem_be  = st_be;
        mem_wd  = st_wdata_lane;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_we  = 1'b1;
                mem_idx = sweep_q;
                mem_be  = 4'b1111;
                mem_wd  = '0;
            end else if (accept && req_we && !req_err) begin
                mem_we  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
        if (accept && !req_we) begin
            raw_q <= mem[req_idx];
        end
    end

    // Response registers; lane selection happens after the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_q        <= 1'b0;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & req_err;
            ld_q        <= accept & ~req_we & ~req_err;
            if (accept) begin
                size_q <= req_sz;
                off_q  <= req_off;
                uns_q  <= req_unsigned;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = ld_q ? ld_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: expected responses are queued when a request is
// driven and compared (data, error, latency) when rsp_valid appears.
module tb_dmem_bytelane;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned D      = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_bytelane #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
                check({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("idle_rdata", rsp_rdata, 32'h0);
            check("idle_err", 32'(rsp_err), 32'h0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check({sb[0].tag, "_valid"}, 32'(rsp_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for exactly one edge; back-to-back calls give no bubble.
    task automatic req(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   w = 0;
        while (!req_ready && w < 4 * D) begin
            req_valid = 1'b0;
            tick();
            w++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Called with reset just released and the FSM in INIT; counts busy cycles.
    task automatic sweep_check(input string tag);
        int   n   = 0;
        logic bad = 1'b0;
        while (init_busy && n < 4 * D) begin
            bad |= req_ready;
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(D));
        check({tag, "_ready_low"}, 32'(bad), 32'd0);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = '0;

        // 1: reset, full sweep, then first word reads zero
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);
        reset = 1'b0;
        sweep_check("sweep0");
        req("lw_0", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

        // 2: sub-word loads with sign and zero extension
        req("sw_10",   1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        req("lb_13",   1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0);
        req("lbu_13",  1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h000000DE, 1'b0);
        req("lh_10",   1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
        req("lhu_12",  1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h0000DEAD, 1'b0);
        req("lh_12",   1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0);
        req("lbu_11",  1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h000000BE, 1'b0);
        req("lb_10",   1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0);
        idle(2);

        // 3: byte-lane strobes merge into one word
        req("sw_20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
        req("sb_21", 1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b0);
        req("sh_22", 1'b1, 32'h22, 2'b01, 1'b0, 32'hFFFF55BB, 32'h0, 1'b0);
        req("lw_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h55BBAA44, 1'b0);
        idle(1);

        // 4: error cases, including faulty stores that must not write
        req("lh_21_err",  1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
        req("lw_22_err",  1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        req("sz11_err",   1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        req("lw_oor_err", 1'b0, D * 4,  2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        req("sh_21_err",  1'b1, 32'h21, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        req("sw_22_err",  1'b1, 32'h22, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        req("sb_bad_err", 1'b1, 32'h20, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        req("sw_oor_err", 1'b1, D * 4,  2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        req("lw_20_keep", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h55BBAA44, 1'b0);
        req("lw_0_keep",  1'b0, 32'h0,  2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(2);

        // 5: store then load of the same word in consecutive cycles
        req("sw_40", 1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
        req("lw_40", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
        idle(2);

        // 6a: reset in the same cycle a load is presented drops the response
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        req_size  = 2'b10;
        reset     = 1'b1;
        tick();
        req_valid = 1'b0;
        reset     = 1'b0;
        check("rst_drop_valid", 32'(rsp_valid), 32'd0);
        // 6b: reset again mid-sweep, sweep must restart from word 0
        repeat (D / 2) tick();
        check("mid_sweep_busy", 32'(init_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_check("sweep1");
        req("lw_40_zero", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        req("lw_10_zero", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        req("lw_20_zero", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
